// File: rtl/rtc_bus_scheduler.sv
// rtl/rtc_bus_scheduler.sv - arbiter/sequencer sharing the RTC bus between a periodic time scan and host writes
module rtc_bus_scheduler #(
  parameter int         N_REGS      = 6,
  parameter logic [7:0] READ_BASE   = 8'h21,
  parameter int         REFRESH_DIV = 100000,
  parameter int         GAP_CYCLES  = 4,
  parameter int         TIMEOUT     = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [7:0]            wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  scan_now,
  input  logic                  dir_flag,
  input  logic                  dat_flag,
  input  logic                  done,
  input  logic [7:0]            bus_in,
  output logic                  en_esc,
  output logic                  en_lect,
  output logic [7:0]            bus_out,
  output logic                  wr_ack,
  output logic [8*N_REGS-1:0]   time_out,
  output logic                  time_valid,
  output logic                  busy,
  output logic                  err
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(N_REGS + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, WR_TXN, RD_TXN, GAP} state_t;

  state_t        state, next_state;
  logic [RW-1:0] refresh_cnt;
  logic          scan_pending;
  logic          scan_active;
  logic [IW-1:0] idx;
  logic [WW-1:0] wdog;
  logic [GW-1:0] gap_cnt;
  logic          done_d;
  logic [7:0]    shadow [N_REGS];

  logic en_any, done_rise, wd_expired, gap_end, refresh_tick;
  logic start_scan, wr_done, rd_done, abort, publish;

  assign en_any       = en_esc | en_lect;
  assign done_rise    = done & ~done_d & en_any;
  assign wd_expired   = en_any & ~done_rise & (wdog == WW'(TIMEOUT - 1));
  // GAP state is one cycle shorter than the low window: the enable rises a cycle after RD_TXN is entered
  assign gap_end      = (gap_cnt == GW'(GAP_CYCLES - 2));
  assign refresh_tick = (refresh_cnt == RW'(REFRESH_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    start_scan = 1'b0;
    wr_done    = 1'b0;
    rd_done    = 1'b0;
    abort      = 1'b0;
    publish    = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req) begin
          next_state = WR_TXN;
        end else if (scan_pending) begin
          next_state = RD_TXN;
          start_scan = 1'b1;
        end
      end
      WR_TXN: begin
        if (done_rise) begin
          wr_done    = 1'b1;
          next_state = GAP;
        end else if (wd_expired) begin
          abort      = 1'b1;
          next_state = GAP;
        end
      end
      RD_TXN: begin
        if (done_rise) begin
          rd_done    = 1'b1;
          next_state = GAP;
        end else if (wd_expired) begin
          abort      = 1'b1;
          next_state = GAP;
        end
      end
      GAP: begin
        if (gap_end) begin
          if (scan_active && (idx < IW'(N_REGS))) begin
            next_state = RD_TXN;
          end else begin
            next_state = IDLE;
            publish    = scan_active && (idx == IW'(N_REGS));
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt  <= '0;
      scan_pending <= 1'b0;
      scan_active  <= 1'b0;
      idx          <= '0;
      wdog         <= '0;
      gap_cnt      <= '0;
      done_d       <= 1'b0;
      en_esc       <= 1'b0;
      en_lect      <= 1'b0;
      bus_out      <= 8'h00;
      wr_ack       <= 1'b0;
      time_out     <= '0;
      time_valid   <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
      for (int i = 0; i < N_REGS; i++) shadow[i] <= 8'h00;
    end else begin
      done_d      <= done;
      refresh_cnt <= refresh_tick ? '0 : refresh_cnt + RW'(1);

      // a trigger landing while one is already pending (or just being taken) is merged
      if (start_scan)                     scan_pending <= 1'b0;
      else if (refresh_tick || scan_now)  scan_pending <= 1'b1;

      if (start_scan)             scan_active <= 1'b1;
      else if (publish || abort)  scan_active <= 1'b0;

      if (start_scan)   idx <= '0;
      else if (rd_done) idx <= idx + IW'(1);

      if (en_any && ((state == WR_TXN) || (state == RD_TXN))) wdog <= wdog + WW'(1);
      else                                                   wdog <= '0;

      gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;

      en_esc     <= (state == WR_TXN) && (next_state == WR_TXN);
      en_lect    <= (state == RD_TXN) && (next_state == RD_TXN);
      wr_ack     <= wr_done;
      err        <= abort;
      time_valid <= publish;
      busy       <= (next_state != IDLE);

      if (state == WR_TXN) begin
        if (dir_flag)      bus_out <= wr_addr;
        else if (dat_flag) bus_out <= wr_data;
      end else if ((state == RD_TXN) && dir_flag) begin
        bus_out <= READ_BASE + 8'(idx);
      end

      if ((state == RD_TXN) && dat_flag && (idx < IW'(N_REGS))) shadow[idx] <= bus_in;

      if (publish) begin
        for (int i = 0; i < N_REGS; i++) time_out[8*i +: 8] <= shadow[i];
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// tb/tb_rtc_bus_scheduler.sv - directed bench with a bus-cycle generator and RTC register model
`timescale 1ns/1ps
module tb_rtc_bus_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset0, reset1;
  logic       wr_req, scan_now;
  logic [7:0] wr_addr, wr_data;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // instance 0 takes directed traffic; instance 1 free-runs with a short refresh period
  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic        rst, dir_flag, dat_flag, done, hold, en;
    logic [7:0]  bus_in, bus_out;
    logic        en_esc, en_lect, wr_ack, time_valid, busy, err;
    logic [47:0] time_out;
    logic [7:0]  gcnt = 8'h00;
    logic [7:0]  addr_lat = 8'h00;
    logic [7:0]  data_lat = 8'h00;
    logic [7:0]  mem [256];
    logic        en_d = 1'b0, esc_d = 1'b0, lect_d = 1'b0, dat_d = 1'b0, busy_d = 1'b0, done_d = 1'b0;
    int acks = 0, valids = 0, errs = 0, rd_wins = 0, wr_wins = 0, overlaps = 0;
    int drop_read = -1;
    int en_len = 0, last_len = 0, low_run = 0, win_in_scan = 0, gaps = 0, gap_bad = 0, cyc = 0;
    int          starts[$];
    int          events[$];
    logic [7:0]  rd_addrs[$];
    logic [7:0]  wr_bytes[$];

    assign rst      = (g == 0) ? reset0 : reset1;
    assign en       = en_esc | en_lect;
    assign dir_flag = en && (gcnt >= 8'd2) && (gcnt <= 8'd5);
    assign dat_flag = en && (gcnt >= 8'd8) && (gcnt <= 8'd11);
    assign hold     = (drop_read == rd_wins) && en_lect;
    assign done     = ((gcnt == 8'd15) || (gcnt == 8'd16)) && !hold;
    assign bus_in   = dat_flag ? mem[addr_lat] : 8'hee;

    rtc_bus_scheduler #(.REFRESH_DIV(g == 0 ? 100000 : 200)) dut (
      .clk        (clk),
      .reset      (rst),
      .wr_req     (g == 0 ? wr_req : 1'b0),
      .wr_addr    (g == 0 ? wr_addr : 8'h00),
      .wr_data    (g == 0 ? wr_data : 8'h00),
      .scan_now   (g == 0 ? scan_now : 1'b0),
      .dir_flag   (dir_flag),
      .dat_flag   (dat_flag),
      .done       (done),
      .bus_in     (bus_in),
      .en_esc     (en_esc),
      .en_lect    (en_lect),
      .bus_out    (bus_out),
      .wr_ack     (wr_ack),
      .time_out   (time_out),
      .time_valid (time_valid),
      .busy       (busy),
      .err        (err)
    );

    always @(posedge clk) begin
      if (rst) begin
        gcnt <= 8'h00;
        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        for (int i = 0; i < 6; i++) mem[8'h21 + i] <= 8'h10 + 8'(i);
      end else begin
        gcnt <= en ? gcnt + 8'd1 : 8'h00;
        if (en && gcnt == 8'd7)  addr_lat <= bus_out;
        if (en && gcnt == 8'd13) data_lat <= bus_out;
        if (en_esc && gcnt == 8'd15) mem[addr_lat] <= data_lat;
      end
    end

    always @(negedge clk) begin
      cyc    <= cyc + 1;
      en_d   <= en;
      esc_d  <= en_esc;
      lect_d <= en_lect;
      dat_d  <= dat_flag;
      busy_d <= busy;
      done_d <= done;
      if (wr_ack)     begin acks   <= acks + 1;   events.push_back(1); end
      if (time_valid) begin valids <= valids + 1; events.push_back(2); end
      if (err)        begin errs   <= errs + 1;   events.push_back(3); end
      if (en_esc && en_lect)  overlaps <= overlaps + 1;
      if (en_lect && !lect_d) rd_wins  <= rd_wins + 1;
      if (en_esc && !esc_d)   wr_wins  <= wr_wins + 1;
      if (en_lect && dat_flag && !dat_d) rd_addrs.push_back(bus_out);
      if (en_esc && dat_flag && !dat_d)  wr_bytes.push_back(bus_out);
      if (en_esc && done && !done_d)     wr_bytes.push_back(bus_out);
      if (en)        en_len   <= en_d ? en_len + 1 : 1;
      else if (en_d) last_len <= en_len;
      if (busy && !busy_d) starts.push_back(cyc);
      if (!busy) begin
        win_in_scan <= 0;
        low_run     <= 0;
      end else if (en && !en_d) begin
        if (win_in_scan > 0) begin
          gaps <= gaps + 1;
          if (low_run != 4) gap_bad <= gap_bad + 1;
        end
        win_in_scan <= win_in_scan + 1;
        low_run     <= 0;
      end else if (!en) begin
        low_run <= low_run + 1;
      end
    end
  end

  function automatic int cnt(input int which);
    case (which)
      0:       return g_inst[0].valids;
      1:       return g_inst[0].acks;
      2:       return g_inst[0].errs;
      default: return g_inst[0].rd_wins;
    endcase
  endfunction

  task automatic wait_cnt(input int which, input int target, input string tag);
    for (int i = 0; i < 4000 && cnt(which) < target; i++) @(negedge clk);
    check({tag, "_reached"}, 64'(cnt(which) >= target), 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400 && g_inst[0].busy; i++) @(negedge clk);
    check({tag, "_idle"}, 64'(g_inst[0].busy), 0);
  endtask

  task automatic pulse_scan();
    @(negedge clk) scan_now = 1'b1;
    @(negedge clk) scan_now = 1'b0;
  endtask

  function automatic logic [47:0] pack_addrs(input int base);
    logic [47:0] v;
    v = '0;
    for (int i = 0; i < 6; i++) v[8*i +: 8] = g_inst[0].rd_addrs[base + i];
    return v;
  endfunction

  int v0, a0, e0, r0, w0, b0, q0, ev0;

  initial begin
    reset0 = 1'b1; reset1 = 1'b1;
    wr_req = 1'b0; scan_now = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_en_esc",     64'(g_inst[0].en_esc), 0);
    check("rst_en_lect",    64'(g_inst[0].en_lect), 0);
    check("rst_bus_out",    64'(g_inst[0].bus_out), 0);
    check("rst_time_out",   64'(g_inst[0].time_out), 0);
    check("rst_flags",      64'({g_inst[0].wr_ack, g_inst[0].time_valid, g_inst[0].busy, g_inst[0].err}), 0);
    reset0 = 1'b0;
    repeat (5) @(negedge clk);

    // single scan
    v0 = cnt(0); r0 = cnt(3); q0 = g_inst[0].rd_addrs.size();
    pulse_scan();
    wait_cnt(0, v0 + 1, "scan1");
    wait_idle("scan1");
    check("scan1_reads",  64'(cnt(3) - r0), 6);
    check("scan1_valids", 64'(cnt(0) - v0), 1);
    check("scan1_addrs",  pack_addrs(q0), 48'h262524232221);
    check("scan1_time",   g_inst[0].time_out, 48'h151413121110);

    // host write
    a0 = cnt(1); r0 = cnt(3); w0 = g_inst[0].wr_wins; b0 = g_inst[0].wr_bytes.size();
    @(negedge clk) begin wr_addr = 8'h22; wr_data = 8'h59; wr_req = 1'b1; end
    wait_cnt(1, a0 + 1, "wr1");
    wr_req = 1'b0;
    wait_idle("wr1");
    repeat (20) @(negedge clk);
    check("wr1_acks",    64'(cnt(1) - a0), 1);
    check("wr1_windows", 64'(g_inst[0].wr_wins - w0), 1);
    check("wr1_no_read", 64'(cnt(3) - r0), 0);
    check("wr1_addr",    64'(g_inst[0].wr_bytes[b0]), 8'h22);
    check("wr1_data",    64'(g_inst[0].wr_bytes[b0 + 1]), 8'h59);
    check("wr1_mem",     64'(g_inst[0].mem[8'h22]), 8'h59);

    // write and scan trigger in the same cycle: write goes first
    ev0 = g_inst[0].events.size(); v0 = cnt(0); a0 = cnt(1);
    @(negedge clk) begin wr_addr = 8'h30; wr_data = 8'ha5; wr_req = 1'b1; scan_now = 1'b1; end
    @(negedge clk) scan_now = 1'b0;
    wait_cnt(1, a0 + 1, "both_wr");
    wr_req = 1'b0;
    wait_cnt(0, v0 + 1, "both_scan");
    wait_idle("both");
    check("both_first_ack",    64'(g_inst[0].events[ev0]), 1);
    check("both_second_valid", 64'(g_inst[0].events[ev0 + 1]), 2);
    check("both_time",         g_inst[0].time_out, 48'h151413125910);

    // write raised during read #3 waits for the scan to finish
    ev0 = g_inst[0].events.size(); r0 = cnt(3); a0 = cnt(1);
    pulse_scan();
    wait_cnt(3, r0 + 3, "mid_rd3");
    wr_addr = 8'h40; wr_data = 8'h66; wr_req = 1'b1;
    wait_cnt(1, a0 + 1, "mid_wr");
    wr_req = 1'b0;
    wait_idle("mid");
    check("mid_first_valid", 64'(g_inst[0].events[ev0]), 2);
    check("mid_then_ack",    64'(g_inst[0].events[ev0 + 1]), 1);
    check("mid_reads",       64'(cnt(3) - r0), 6);

    // done withheld on read #2
    v0 = cnt(0); e0 = cnt(2); r0 = cnt(3);
    g_inst[0].drop_read = r0 + 2;
    pulse_scan();
    wait_cnt(2, e0 + 1, "to_err");
    wait_idle("to");
    repeat (10) @(negedge clk);
    check("to_errs",     64'(cnt(2) - e0), 1);
    check("to_len",      64'(g_inst[0].last_len), 63);
    check("to_reads",    64'(cnt(3) - r0), 2);
    check("to_no_valid", 64'(cnt(0) - v0), 0);
    check("to_time_kept", g_inst[0].time_out, 48'h151413125910);
    g_inst[0].drop_read = -1;
    v0 = cnt(0); r0 = cnt(3);
    pulse_scan();
    wait_cnt(0, v0 + 1, "to_rescan");
    wait_idle("to_rescan");
    check("to_rescan_reads", 64'(cnt(3) - r0), 6);
    check("to_rescan_time",  g_inst[0].time_out, 48'h151413125910);

    // reset during a write data phase
    a0 = cnt(1);
    @(negedge clk) begin wr_addr = 8'h31; wr_data = 8'h77; wr_req = 1'b1; end
    for (int i = 0; i < 200 && !(g_inst[0].dat_flag && g_inst[0].en_esc); i++) @(negedge clk);
    check("rst_mid_in_data", 64'(g_inst[0].dat_flag && g_inst[0].en_esc), 1);
    reset0 = 1'b1;
    #1;
    check("rst_mid_en_esc",   64'(g_inst[0].en_esc), 0);
    check("rst_mid_bus_out",  64'(g_inst[0].bus_out), 0);
    check("rst_mid_time_out", 64'(g_inst[0].time_out), 0);
    check("rst_mid_flags",    64'({g_inst[0].en_lect, g_inst[0].wr_ack, g_inst[0].time_valid, g_inst[0].busy, g_inst[0].err}), 0);
    @(negedge clk) reset0 = 1'b0;
    wait_cnt(1, a0 + 1, "rst_retry");
    wr_req = 1'b0;
    wait_idle("rst_retry");
    repeat (20) @(negedge clk);
    check("rst_retry_acks", 64'(cnt(1) - a0), 1);
    check("rst_retry_mem",  64'(g_inst[0].mem[8'h31]), 8'h77);
    check("inst0_overlap",  64'(g_inst[0].overlaps), 0);

    // free-running periodic scans on the short-period instance
    @(negedge clk) reset1 = 1'b0;
    repeat (1000) @(negedge clk);
    check("per_scans_ge4", 64'(g_inst[1].starts.size() >= 4), 1);
    for (int i = 1; i < g_inst[1].starts.size(); i++)
      check($sformatf("per_period_%0d", i), 64'(g_inst[1].starts[i] - g_inst[1].starts[i-1]), 200);
    check("per_gaps_ge20", 64'(g_inst[1].gaps >= 20), 1);
    check("per_gap_bad",   64'(g_inst[1].gap_bad), 0);
    check("per_overlap",   64'(g_inst[1].overlaps), 0);
    check("per_valids_ge4", 64'(g_inst[1].valids >= 4), 1);
    check("per_time",      g_inst[1].time_out, 48'h151413121110);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule

// File: doc/rtc_bus_scheduler.md
# rtc_bus_scheduler

Sequencer and arbiter in front of the RTC bus-cycle generator (the block producing CS/WR/RD/AD, DIR/DAT flags, transaction-done and tri-state enable). It is the only block that drives the generator's write and read enables. It shares the single RTC bus between two requesters: a periodic time-register scan, and host write requests. It supplies the address/data byte the tri-state driver puts on the bus and publishes a coherent snapshot of the time registers.

## Interface
- N_REGS, 6: registers read per scan (seconds through year)
- READ_BASE, 8'h21: RTC address of first scanned register; register i is at READ_BASE+i
- REFRESH_DIV, 100000: clk cycles between scan triggers
- GAP_CYCLES, 4: cycles both enables stay low between transactions; minimum 2
- TIMEOUT, 63: max cycles an enable may stay high without a done pulse

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- wr_req  in  1  host write request, level; held until wr_ack
- wr_addr  in  8  RTC register address for write
- wr_data  in  8  data byte for write
- scan_now  in  1  one-cycle pulse; forces a scan trigger
- dir_flag  in  1  generator address-phase flag
- dat_flag  in  1  generator data-phase flag
- done  in  1  generator transaction-done flag; 2 cycles wide
- bus_in  in  8  byte sampled from RTC bus
- en_esc  out  1  write-transaction enable to generator
- en_lect  out  1  read-transaction enable to generator
- bus_out  out  8  byte for tri-state driver
- wr_ack  out  1  one-cycle pulse; host write completed
- time_out  out  8*N_REGS  snapshot; register i is in bits [8i+7:8i]
- time_valid  out  1  one-cycle pulse; time_out updated
- busy  out  1  high in any state except IDLE
- err  out  1  one-cycle pulse on timeout

## Operation
- States: IDLE, WR_TXN, RD_TXN, GAP.
- **Refresh counter**
  - Free-running, 0..REFRESH_DIV-1.
  - Wraps to 0 and sets scan_pending on reaching REFRESH_DIV-1.
  - scan_now also sets scan_pending.
  - A trigger while scan_pending is already set is merged; triggers are not queued.
- **IDLE**
  - If wr_req: go to WR_TXN. A write wins over a simultaneous scan_pending.
  - Else if scan_pending: clear scan_pending, set idx=0, go to RD_TXN.
- **WR_TXN**
  - en_esc=1.
  - bus_out=wr_addr while dir_flag=1, wr_data while dat_flag=1, hold last value otherwise.
  - On done rising edge: en_esc=0 next cycle, wr_ack pulse, go to GAP.
- **RD_TXN**
  - en_lect=1.
  - bus_out=READ_BASE+idx while dir_flag=1.
  - shadow[idx] <= bus_in every cycle dat_flag=1, so the last dat_flag cycle's value is kept.
  - On done rising edge: en_lect=0 and idx+1, go to GAP.
- **GAP**
  - Both enables 0 for GAP_CYCLES cycles. This lets the generator counter return to 0.
  - Then:
    - If a scan is in progress and idx<N_REGS: go to RD_TXN.
    - If idx==N_REGS: copy shadow to time_out, pulse time_valid, clear the scan-in-progress flag, go to IDLE.
    - Otherwise: go to IDLE.
- **Scan atomicity:** a scan, once started, is atomic. wr_req arriving mid-scan waits until the scan has completed and returned to IDLE.
- **Done detection:** rising edge only (done & ~done_d). The second done cycle is ignored.
- **Timeout**
  - A watchdog counts cycles in WR_TXN/RD_TXN. Reaching TIMEOUT drops the enable, pulses err, and goes to GAP.
  - An aborted scan is discarded: time_out is unchanged, no time_valid, scan-in-progress cleared.
  - An aborted write gives no wr_ack; the write is retried while wr_req stays high.
- **Enable invariant:** en_esc and en_lect are never high simultaneously.
- **Reset**
  - All outputs 0: en_esc, en_lect, bus_out, wr_ack, time_out, time_valid, busy, err.
  - State IDLE, refresh counter 0, scan_pending 0, shadow 0.
  - Reset mid-transaction drops the enable immediately (asynchronous).

## Timing
- All outputs registered.
- Enables rise the cycle after the state is entered. They fall the cycle after the done rising edge.
- Gap between transactions: exactly GAP_CYCLES cycles with both enables low.
- bus_out follows dir_flag/dat_flag with 1 cycle of latency. The generator's flag windows open ≥2 cycles before the tri-state is enabled, so the byte is stable in time.
- wr_ack and time_valid occur 1 cycle after the done edge and GAP exit respectively.
- Scan duration ≈ N_REGS × (transaction length + 1 + GAP_CYCLES).

## Test plan
- Generator model; scan_now pulse, bus_in returns 8'h10+idx during dat_flag → 6 read transactions with addresses 21..26 on bus_out; one time_valid; time_out=48'h151413121110.
- wr_req, wr_addr=8'h22, wr_data=8'h59 → one en_esc window; bus_out 22 then 59; wr_ack exactly once; en_lect stays 0.
- wr_req and scan_now in the same cycle → write completes first, then the 6-read scan. wr_req raised during read #3 → served only after time_valid.
- Model withholds done on read #2 → err after 63 enable cycles, scan aborted, time_out unchanged, next trigger scans fully.
- REFRESH_DIV=200, no requests, 1000 cycles → scans start every 200 cycles, gaps of exactly 4 low cycles between transactions, no overlapping enables.
- Assert reset during a write data phase → en_esc low the same cycle, all outputs 0. After release, the held wr_req is re-served with a single wr_ack.
